// File: rtl/bp_pkg.sv
// Shared selector-table definitions for the tournament predictor.
package bp_pkg;

    localparam int unsigned DEF_IDX_W    = 10;
    localparam logic [1:0]  DEF_INIT_VAL = 2'b01;

    // Selector encodings: bit1 = 1 selects the local predictor.
    localparam logic [1:0] SEL_SG = 2'b00;
    localparam logic [1:0] SEL_WG = 2'b01;
    localparam logic [1:0] SEL_WL = 2'b10;
    localparam logic [1:0] SEL_SL = 2'b11;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } upd_state_e;

    // Saturating selector update; returns cur unchanged when both agree.
    function automatic logic [1:0] sel_update(input logic [1:0] cur,
                                              input logic       global_ok,
                                              input logic       local_ok);
        logic [1:0] nxt;
        nxt = cur;
        if (!global_ok && local_ok) begin
            if (cur != SEL_SL) nxt = cur + 2'd1;
        end else if (global_ok && !local_ok) begin
            if (cur != SEL_SG) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_sel_update_ctrl_if.sv
// M-stage update and selector-table port bundle.
interface bp_sel_update_ctrl_if #(
    parameter int unsigned IDX_W = bp_pkg::DEF_IDX_W
);
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_global_ok;
    logic             upd_local_ok;
    logic             upd_ready;
    logic             inval_req;
    logic [IDX_W-1:0] tbl_rd_idx;
    logic [1:0]       tbl_rd_data;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_widx;
    logic [1:0]       tbl_wdata;
    logic             tbl_ready;
    logic             busy;

    modport master (
        output upd_valid, upd_idx, upd_global_ok, upd_local_ok, inval_req, tbl_rd_data,
        input  upd_ready, tbl_rd_idx, tbl_we, tbl_widx, tbl_wdata, tbl_ready, busy
    );

    modport slave (
        input  upd_valid, upd_idx, upd_global_ok, upd_local_ok, inval_req, tbl_rd_data,
        output upd_ready, tbl_rd_idx, tbl_we, tbl_widx, tbl_wdata, tbl_ready, busy
    );
endinterface

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO of pending selector updates with flush.
module bp_upd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
            else if (!push_ok && pop_ok) count <= count - CNT_W'(1);
        end
    end

    // Payload storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bp_sel_update_ctrl.sv
// Write-port scheduler for the selector table: init sweep plus queued RMW updates.
module bp_sel_update_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W    = DEF_IDX_W,
    parameter int unsigned Q_DEPTH  = 4,
    parameter logic [1:0]  INIT_VAL = DEF_INIT_VAL
) (
    input logic                clk,
    input logic                rst,
    bp_sel_update_ctrl_if.slave bus
);
    localparam int unsigned ENT_W = IDX_W + 2;

    upd_state_e       state;
    logic [IDX_W-1:0] sweep_idx;
    logic             tbl_ready_q;

    logic [ENT_W-1:0] q_din;
    logic [ENT_W-1:0] q_dout;
    logic             q_full;
    logic             q_empty;
    logic             q_push;
    logic             q_pop;
    logic [IDX_W-1:0] head_idx;
    logic             head_g;
    logic             head_l;

    assign q_din                      = {bus.upd_idx, bus.upd_global_ok, bus.upd_local_ok};
    assign {head_idx, head_g, head_l} = q_dout;

    // An invalidate discards any update offered in the same cycle.
    assign bus.upd_ready = rst && !q_full;
    assign q_push        = bus.upd_valid && bus.upd_ready && !bus.inval_req;

    assign bus.tbl_rd_idx = head_idx;
    assign bus.tbl_ready  = tbl_ready_q;
    assign bus.busy       = (state == SWEEP) || !q_empty;

    bp_upd_fifo #(
        .DEPTH (Q_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.inval_req),
        .push  (q_push),
        .din   (q_din),
        .pop   (q_pop),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty)
    );

    // Sweep/run sequencing; invalidate restarts the sweep from index 0.
    always_ff @(posedge clk) begin
        if (!rst || bus.inval_req) begin
            state       <= SWEEP;
            sweep_idx   <= '0;
            tbl_ready_q <= 1'b0;
        end else begin
            case (state)
                SWEEP: begin
                    sweep_idx <= sweep_idx + IDX_W'(1);
                    if (sweep_idx == '1) begin
                        state       <= RUN;
                        tbl_ready_q <= 1'b1;
                    end
                end
                RUN:     ;
                default: state <= SWEEP;
            endcase
        end
    end

    // Single table write port: sweep fill or same-cycle read-modify-write of the queue head.
    always_comb begin
        q_pop         = 1'b0;
        bus.tbl_we    = 1'b0;
        bus.tbl_widx  = head_idx;
        bus.tbl_wdata = sel_update(bus.tbl_rd_data, head_g, head_l);
        if (rst && !bus.inval_req) begin
            case (state)
                SWEEP: begin
                    bus.tbl_we    = 1'b1;
                    bus.tbl_widx  = sweep_idx;
                    bus.tbl_wdata = INIT_VAL;
                end
                RUN: begin
                    if (!q_empty) begin
                        q_pop      = 1'b1;
                        bus.tbl_we = head_g ^ head_l;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bp_sel_update_ctrl.md
# bp_sel_update_ctrl

Write-port scheduler for the tournament predictor's 2-bit selector table (CPHT). It owns all writes to the table: a multi-cycle initialization sweep after reset or invalidate, and buffered read-modify-write updates retired from the M stage. It sits between the M-stage branch-resolution signals and the selector table RAM. It exposes `tbl_ready` so the F-stage lookup falls back to a defined selection until the table is valid.

## Interface
- `IDX_W`, 10: selector table index width; the table has 2^IDX_W entries.
- `Q_DEPTH`, 4: update queue depth; must be a power of 2, minimum 2.
- `INIT_VAL`, 2'b01: value written to every entry during a sweep (weak-global).

Ports:
- `clk` in, 1: clock.
- `rst` in, 1: reset, synchronous, active-low.
- `upd_valid` in, 1: M-stage branch update request.
- `upd_idx` in, IDX_W: hashed PC index of the resolved branch.
- `upd_global_ok` in, 1: the global predictor was correct.
- `upd_local_ok` in, 1: the local predictor was correct.
- `upd_ready` out, 1: the queue can accept an update this cycle.
- `inval_req` in, 1: single-cycle pulse; invalidate the table.
- `tbl_rd_idx` out, IDX_W: table read address; the table read is combinational.
- `tbl_rd_data` in, 2: selector entry at `tbl_rd_idx`.
- `tbl_we` out, 1: table write enable.
- `tbl_widx` out, IDX_W: write address.
- `tbl_wdata` out, 2: write data.
- `tbl_ready` out, 1: the table holds valid data; lookups may use it.
- `busy` out, 1: a sweep is active or the queue is non-empty.

## Operation
- **Encoding** (bit1 = 1 selects local): 00 strong-global, 01 weak-global, 10 weak-local, 11 strong-local.
- **Update rule** (saturating):
  - global wrong and local right: increment (11 holds).
  - global right and local wrong: decrement (00 holds).
  - both right or both wrong: no write (`tbl_we` stays 0 for that pop).
- **FSM states:** SWEEP, RUN.
- **SWEEP:**
  - Each cycle writes `INIT_VAL` to `sweep_idx`, then increments `sweep_idx`.
  - After writing index 2^IDX_W−1, go to RUN.
  - The queue accepts but does not pop.
- **RUN:**
  - If the queue is non-empty, pop the head.
  - Drive `tbl_rd_idx` = head index and compute the new value from `tbl_rd_data`.
  - Write in the same cycle. One pop per cycle.
- **Queue:**
  - A push happens when `upd_valid` && `upd_ready`; `upd_ready` = !full.
  - No same-cycle pass-through when full.
  - When `upd_ready` is low, the pipeline stalls M; updates are never dropped.
- **`inval_req`:**
  - Takes effect in any state.
  - Flushes the queue, sets `sweep_idx` to 0 and enters SWEEP.
  - An `upd_valid` in the same cycle is discarded.
  - `tbl_ready` drops at the next edge.
- **Same index back-to-back:** the second pop reads the value written by the first. No forwarding is needed because the write lands at the edge between the two pops.

## Timing
- **While `rst` = 0:**
  - State SWEEP, `sweep_idx` = 0, queue empty.
  - `tbl_we` = 0, `tbl_ready` = 0, `busy` = 1, `upd_ready` = 0.
- **Sweep:**
  - The first sweep write is in the first cycle with `rst` = 1.
  - The sweep takes exactly 2^IDX_W cycles.
  - `tbl_ready` goes to 1 in the cycle after the last sweep write.
- **Update latency:**
  - An update accepted at edge N into an empty queue in RUN is written at edge N+1.
  - Writes are visible to reads from cycle N+2.
- **`busy`:** falls in the first cycle with RUN and the queue empty.
- **Reset mid-sweep or mid-drain:** aborts everything and restarts the sweep from index 0 after release.
- **Queue pointers:** wrap modulo Q_DEPTH, with an explicit count for full/empty.
- **Simultaneous push and pop when full:** the push is refused, because `upd_ready` was 0.

## Structure
- Shared package `bp_pkg`: selector encodings `SEL_SG`, `SEL_WG`, `SEL_WL`, `SEL_SL`, default `IDX_W`, default `INIT_VAL`, and the FSM state enum. The predictor and lookup logic reuse these.
- Sub-module `bp_upd_fifo`: a synchronous FIFO of {idx, global_ok, local_ok}, parameterized by depth and width, with a flush input.
- The saturating-update function lives in `bp_pkg`.

## Test plan
- **Reset sweep (IDX_W=4):** release `rst` → exactly 16 writes of 01 to indices 0..15, then `tbl_ready` = 1 in cycle 17.
- **Single update:** idx 5 at 01 with global wrong, local right → write 10 to idx 5 one cycle after acceptance. Repeat twice → 11, then no further change.
- **Decrement, saturation, no-op:** idx 3 at 01 with global right, local wrong → 00, then holds at 00. With both right → no `tbl_we`.
- **Backpressure (Q_DEPTH=4):** push 5 updates during the sweep → `upd_ready` = 0 after the 4th. After RUN starts, they drain in order at one per cycle.
- **Invalidate:** `inval_req` while 3 entries are queued → queue emptied, `tbl_ready` = 0 next cycle, a full sweep rewrites 01, and the queued updates never reach the table.
- **Same index back-to-back:** two queued increments to idx 7 from 01 → writes 10, then 11 on consecutive cycles.
